loop_engine: RTL and testbench
==============================

LOOP_ENGINE -- requirements
Module: loop_engine

Interface
REQ-001 Parameter DATA_W, default 8, data width of the rx and tx FIFO ports.
REQ-002 Parameter XOR_KEY, default 8'hA5 (DATA_W bits), key for XOR mode.
REQ-003 Parameter THRESH, default 8'h80 (DATA_W bits), threshold for binarise mode.
REQ-004 Parameter CNT_W, default 32, width of the word counter.
REQ-005 clk_pll  in  1  system clock; all logic on its rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 enable  in  1  high permits new rx FIFO reads.
REQ-008 mode  in  2  transform select: 0 pass, 1 invert, 2 XOR key, 3 binarise.
REQ-009 rx_dout  in  DATA_W  rx FIFO read data, valid the cycle after rx_rd (standard, non-FWFT FIFO).
REQ-010 rx_empty  in  1  rx FIFO empty.
REQ-011 rx_rd  out  1  rx FIFO read strobe, one cycle per word.
REQ-012 tx_full  in  1  tx FIFO full.
REQ-013 tx_wr  out  1  tx FIFO write strobe, one cycle per word.
REQ-014 tx_data  out  DATA_W  registered transformed word, valid while tx_wr=1.
REQ-015 word_cnt  out  CNT_W  count of words written to tx FIFO.
REQ-016 busy  out  1  high when the FSM is not in IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH and PUSH.
REQ-018 IDLE: if enable=1, rx_empty=0 and tx_full=0, SHALL assert rx_rd for one cycle and go to FETCH; otherwise SHALL stay in IDLE.
REQ-019 FETCH: SHALL register transform(rx_dout, mode) into the hold register and go to PUSH; mode is sampled in this cycle only.
REQ-020 PUSH: if tx_full=1, SHALL hold tx_wr=0 and retain the hold register.
REQ-021 PUSH: if tx_full=0, SHALL assert tx_wr with tx_data equal to the hold register.
REQ-022 PUSH with the write: if enable=1 and rx_empty=0, SHALL also assert rx_rd in the same cycle and go to FETCH; otherwise SHALL go to IDLE.
REQ-023 Sustained throughput SHALL be one word per two cycles; first-word latency from rx_rd to tx_wr SHALL be 2 cycles when tx_full=0.
REQ-024 Transforms: pass = d; invert = ~d; XOR = d ^ XOR_KEY; binarise = all ones if d >= THRESH (unsigned), else all zeros.
REQ-025 rx_rd SHALL never be asserted while rx_empty=1, and tx_wr SHALL never be asserted while tx_full=1.
REQ-026 No word SHALL be dropped or duplicated; at most one word is in flight.
REQ-027 enable deassertion SHALL not abort an in-flight word: FETCH/PUSH complete, then the FSM returns to IDLE.
REQ-028 A mode change SHALL affect only words fetched after the change.
REQ-029 word_cnt SHALL increment by 1 on every tx_wr and wrap from all ones to 0.
REQ-030 tx_data SHALL be driven from the hold register at all times (no combinational path from rx_dout).

Reset
REQ-031 When reset_n=0, SHALL force state IDLE, rx_rd=0, tx_wr=0, tx_data=0, word_cnt=0, busy=0 and hold=0, asynchronously.
REQ-032 Reset asserted mid-word SHALL discard that word; after release the FSM SHALL resume from IDLE on the next qualifying edge.
REQ-033 Deassertion of reset_n is synchronised externally (PLL lock); no internal synchroniser is required.

Structure
REQ-034 A shared package loop_pkg SHALL hold the mode encodings (MODE_PASS, MODE_INV, MODE_XOR, MODE_BIN) and the FSM state enumeration.
REQ-035 The transform SHALL be a separate combinational sub-module, loop_xform (inputs d and mode; output q), instantiated once.
REQ-036 The top-level integration SHALL instantiate loop_engine in place of the fixed looper plus inverter, driving the async-FIFO tx data directly.

Verification
REQ-037 mode=1, rx FIFO holds 00,FF,3C, tx_full=0 -> tx receives FF,00,C3 in order, tx_wr two cycles apart, word_cnt=3.
REQ-038 mode=2, XOR_KEY=A5, rx FIFO holds 5A -> tx receives FF; mode=3, rx FIFO holds 7F,80 -> tx receives 00,FF.
REQ-039 tx_full held high for 10 cycles during PUSH -> tx_wr=0 throughout, then one tx_wr with the unchanged word, no rx_rd while stalled.
REQ-040 enable dropped in the FETCH cycle with 4 words queued -> exactly one word written, then IDLE with busy=0; re-enable -> remaining 3 words follow.
REQ-041 reset_n pulsed low in PUSH -> outputs zero immediately, that word is not written, word_cnt=0, and the next queued word flows after release.
REQ-042 CNT_W=4, 17 words streamed -> word_cnt wraps to 0 after the 16th word and reads 1 at the end.

Source files
------------

// File: rtl/loop_pkg.sv
// Shared encodings for the loop engine: transform select and FSM states.
package loop_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_INV  = 2'd1,
    MODE_XOR  = 2'd2,
    MODE_BIN  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PUSH  = 2'd2
  } state_e;

endpackage

// File: rtl/loop_xform.sv
// Combinational word transform: pass, invert, XOR with key, or binarise.
module loop_xform
  import loop_pkg::*;
#(
  parameter int unsigned       DATA_W  = 8,
  parameter logic [DATA_W-1:0] XOR_KEY = DATA_W'(8'hA5),
  parameter logic [DATA_W-1:0] THRESH  = DATA_W'(8'h80)
) (
  input  logic [DATA_W-1:0] d,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] q
);

  always_comb begin
    q = d;
    case (mode_e'(mode))
      MODE_PASS: q = d;
      MODE_INV:  q = ~d;
      MODE_XOR:  q = d ^ XOR_KEY;
      MODE_BIN:  q = (d >= THRESH) ? '1 : '0;
      default:   q = d;
    endcase
  end

endmodule

// File: rtl/loop_engine.sv
// Moves words from a standard rx FIFO to a tx FIFO, one at a time, applying
// a selectable transform; counts written words.
module loop_engine
  import loop_pkg::*;
#(
  parameter int unsigned       DATA_W  = 8,
  parameter logic [DATA_W-1:0] XOR_KEY = DATA_W'(8'hA5),
  parameter logic [DATA_W-1:0] THRESH  = DATA_W'(8'h80),
  parameter int unsigned       CNT_W   = 32
) (
  input  logic              clk_pll,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] rx_dout,
  input  logic              rx_empty,
  output logic              rx_rd,
  input  logic              tx_full,
  output logic              tx_wr,
  output logic [DATA_W-1:0] tx_data,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] xf;
  logic [CNT_W-1:0]  cnt_q;
  logic              can_fetch;

  loop_xform #(
    .DATA_W  (DATA_W),
    .XOR_KEY (XOR_KEY),
    .THRESH  (THRESH)
  ) u_xform (
    .d    (rx_dout),
    .mode (mode),
    .q    (xf)
  );

  assign can_fetch = reset_n & enable & ~rx_empty;

  // Strobes decode from the registered state and the live FIFO flags, so a
  // flag that changes this cycle can never be overrun.
  always_comb begin
    rx_rd   = 1'b0;
    tx_wr   = 1'b0;
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (can_fetch && !tx_full) begin
          rx_rd   = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: state_d = PUSH;
      PUSH: begin
        if (!tx_full) begin
          tx_wr = 1'b1;
          if (can_fetch) begin
            rx_rd   = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_pll or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH) hold_q <= xf;
      if (tx_wr)            cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign tx_data  = hold_q;
  assign word_cnt = cnt_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_loop_engine.sv
// Bench for loop_engine: FIFO models on both sides, a per-word reference
// transform, directed scenarios and randomized traffic.
module tb_loop_engine;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk_pll  = 1'b0;
  logic          reset_n  = 1'b0;
  logic          enable   = 1'b0;
  logic [1:0]    mode     = 2'd0;
  logic [DW-1:0] rx_dout  = '0;
  logic          rx_empty;
  logic          rx_rd;
  logic          tx_full  = 1'b0;
  logic          tx_wr;
  logic [DW-1:0] tx_data;
  logic [CW-1:0] word_cnt;
  logic          busy;

  always #5 clk_pll = ~clk_pll;

  loop_engine #(
    .DATA_W  (DW),
    .XOR_KEY (8'hA5),
    .THRESH  (8'h80),
    .CNT_W   (CW)
  ) dut (
    .clk_pll  (clk_pll),
    .reset_n  (reset_n),
    .enable   (enable),
    .mode     (mode),
    .rx_dout  (rx_dout),
    .rx_empty (rx_empty),
    .rx_rd    (rx_rd),
    .tx_full  (tx_full),
    .tx_wr    (tx_wr),
    .tx_data  (tx_data),
    .word_cnt (word_cnt),
    .busy     (busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] rx_mem  [1024];
  logic [7:0] exp_mem [1024];
  logic [7:0] wr_val  [1024];
  int         wr_cyc  [1024];
  int         rd_cyc  [1024];
  bit         skip_flag [1024];

  int   wr_ptr = 0, rd_ptr = 0;
  int   n_rd = 0, n_wr = 0, n_skip = 0;
  int   v_rd_empty = 0, v_wr_full = 0, v_spur = 0;
  logic rd_pend = 1'b0;
  int   chk_ptr = 0, cnt_base = 0;

  always @(posedge clk_pll) cyc <= cyc + 1;

  assign rx_empty = (rd_ptr == wr_ptr);

  // Standard FIFO: data appears the cycle after the read strobe.
  always @(posedge clk_pll) begin
    if (rd_pend) begin
      rx_dout <= rx_mem[rd_ptr];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  always @(negedge clk_pll) begin : mon
    int k;
    rd_pend = rx_rd && !rx_empty;
    if (rx_rd) begin
      if (rx_empty) v_rd_empty++;
      rd_cyc[n_rd] = cyc;
      n_rd++;
    end
    if (tx_wr) begin
      if (tx_full) v_wr_full++;
      k = n_wr + n_skip;
      if (k >= wr_ptr) v_spur++;
      else begin
        wr_val[k] = tx_data;
        wr_cyc[k] = cyc;
      end
      n_wr++;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_xform(input logic [7:0] d, input int m);
    int v = int'(d);
    case (m)
      0:       return d;
      1:       return 8'(255 - v);
      2:       return d ^ 8'hA5;
      default: return (v >= 128) ? 8'hFF : 8'h00;
    endcase
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_pll);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    rx_mem[wr_ptr]  = d;
    exp_mem[wr_ptr] = ref_xform(d, int'(mode));
    wr_ptr++;
  endtask

  task automatic drain(input string tag);
    int budget = 400;
    while (n_wr + n_skip < wr_ptr && budget > 0) begin
      tick();
      budget--;
    end
    check({tag, "_drain"}, n_wr + n_skip, wr_ptr);
    tick(2);
    check({tag, "_busy"}, busy, 0);
    for (int k = chk_ptr; k < wr_ptr; k++)
      if (!skip_flag[k]) check({tag, "_data"}, wr_val[k], exp_mem[k]);
    chk_ptr = wr_ptr;
    check({tag, "_cnt"}, word_cnt, (n_wr - cnt_base) % 16);
    check({tag, "_proto"}, v_rd_empty + v_wr_full + v_spur, 0);
  endtask

  task automatic wait_rd(input string tag);
    int r0 = n_rd;
    int b  = 50;
    while (n_rd == r0 && b > 0) begin
      tick();
      b--;
    end
    check({tag, "_rd_seen"}, (n_rd != r0), 1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(1);
    cnt_base = n_wr;
    reset_n  = 1'b1;
    tick(1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b, w0, r0, lim, npush, pushed;

    // Reset state, with a word waiting and enable high
    enable = 1'b1;
    push(8'h11);
    tick(2);
    check("rst_rx_rd", rx_rd, 0);
    check("rst_tx_wr", tx_wr, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;
    drain("rst_resume");

    // Invert stream: 00,FF,3C -> FF,00,C3, two cycles apart
    enable = 1'b0;
    do_reset();
    mode = 2'd1;
    b = wr_ptr;
    push(8'h00); push(8'hFF); push(8'h3C);
    enable = 1'b1;
    drain("inv");
    check("inv_w0", wr_val[b], 8'hFF);
    check("inv_w1", wr_val[b+1], 8'h00);
    check("inv_w2", wr_val[b+2], 8'hC3);
    check("inv_lat", wr_cyc[b] - rd_cyc[b], 2);
    check("inv_gap1", wr_cyc[b+1] - wr_cyc[b], 2);
    check("inv_gap2", wr_cyc[b+2] - wr_cyc[b+1], 2);
    check("inv_cnt3", word_cnt, 3);

    // XOR and binarise
    mode = 2'd2;
    push(8'h5A);
    drain("xor");
    check("xor_w", wr_val[wr_ptr-1], 8'hFF);
    mode = 2'd3;
    push(8'h7F); push(8'h80);
    drain("bin");
    check("bin_w0", wr_val[wr_ptr-2], 8'h00);
    check("bin_w1", wr_val[wr_ptr-1], 8'hFF);

    // tx_full stall during PUSH
    enable = 1'b0;
    mode = 2'd0;
    b = wr_ptr;
    push(8'h3C); push(8'hC4);
    enable = 1'b1;
    wait_rd("stall");
    tx_full = 1'b1;
    w0 = n_wr;
    r0 = n_rd;
    tick(11);
    check("stall_nowr", n_wr - w0, 0);
    check("stall_nord", n_rd - r0, 0);
    check("stall_hold", tx_data, exp_mem[b]);
    check("stall_busy", busy, 1);
    tx_full = 1'b0;
    drain("stall");
    check("stall_lat", wr_cyc[b] - rd_cyc[b], 12);
    check("stall_next", wr_cyc[b+1] - wr_cyc[b], 2);

    // enable dropped in FETCH with four words queued
    enable = 1'b0;
    mode = 2'd1;
    for (int i = 0; i < 4; i++) push(8'($urandom));
    r0 = n_rd;
    enable = 1'b1;
    wait_rd("en");
    enable = 1'b0;
    w0 = n_wr;
    tick(6);
    check("en_one_wr", n_wr - w0, 1);
    check("en_one_rd", n_rd - r0, 1);
    check("en_idle", busy, 0);
    enable = 1'b1;
    drain("en");

    // Reset pulsed in PUSH discards the in-flight word
    enable = 1'b0;
    mode = 2'd2;
    b = wr_ptr;
    push(8'($urandom)); push(8'($urandom));
    enable = 1'b1;
    wait_rd("rstp");
    tick(1);
    reset_n = 1'b0;
    #1;
    check("rstp_rx_rd", rx_rd, 0);
    check("rstp_tx_wr", tx_wr, 0);
    check("rstp_busy", busy, 0);
    check("rstp_tx_data", tx_data, 0);
    check("rstp_word_cnt", word_cnt, 0);
    skip_flag[b] = 1'b1;
    n_skip++;
    cnt_base = n_wr;
    tick(1);
    reset_n = 1'b1;
    drain("rstp");
    check("rstp_cnt1", word_cnt, 1);

    // 4-bit counter wrap over 17 words
    enable = 1'b0;
    do_reset();
    mode = 2'($urandom_range(0, 3));
    for (int i = 0; i < 17; i++) push(8'($urandom));
    enable = 1'b1;
    lim = 200;
    while (n_wr - cnt_base < 16 && lim > 0) begin
      tick();
      lim--;
    end
    check("wrap_seen16", n_wr - cnt_base, 16);
    check("wrap_cnt0", word_cnt, 0);
    drain("wrap");
    check("wrap_cnt1", word_cnt, 1);

    // Randomized traffic with enable and tx_full toggling
    for (int r = 0; r < 30; r++) begin
      mode   = 2'($urandom_range(0, 3));
      npush  = $urandom_range(1, 8);
      pushed = 0;
      for (int c = 0; c < 40; c++) begin
        if (pushed < npush && $urandom_range(0, 2) == 0) begin
          push(8'($urandom));
          pushed++;
        end
        enable  = ($urandom_range(0, 3) != 0);
        tx_full = ($urandom_range(0, 2) == 0);
        tick(1);
      end
      while (pushed < npush) begin
        push(8'($urandom));
        pushed++;
      end
      enable  = 1'b1;
      tx_full = 1'b0;
      drain("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
